mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter SYNC_BYTE, default 8'h4C, frame start byte.
REQ-002 Parameter TIMEOUT, default 100000, max idle cycles between frame bytes.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  incoming serial byte.
REQ-006 rx_valid  input  1  rx_data valid this cycle.
REQ-007 rx_ready  output  1  loader accepts rx_data this cycle.
REQ-008 mem_addr  output  16  memory write address, to memory addr port.
REQ-009 mem_data  output  8  memory write data, to memory data_in port.
REQ-010 mem_wr  output  1  one-cycle memory write strobe.
REQ-011 cpu_hold  output  1  holds CPU in reset while a frame is in progress.
REQ-012 done  output  1  one-cycle pulse, frame loaded with good checksum.
REQ-013 err  output  1  one-cycle pulse, bad checksum or timeout.

Function
REQ-014 A byte SHALL transfer only on a cycle with rx_valid && rx_ready both high.
REQ-015 Frame format SHALL be SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes, CSUM.
REQ-016 FSM states SHALL be IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, WRITE, CSUM.
REQ-017 IDLE: byte equal to SYNC_BYTE -> ADDR_H; any other byte consumed and dropped, state unchanged.
REQ-018 ADDR_H/ADDR_L/LEN_H/LEN_L: each accepted byte latches into the addr/len register and advances one state.
REQ-019 After LEN_L, LEN == 0 SHALL go to CSUM; otherwise DATA.
REQ-020 DATA: accepted byte latches into mem_data, adds into the 8-bit running sum (mod 256), -> WRITE.
REQ-021 WRITE: mem_wr=1 for exactly one cycle with current mem_addr/mem_data; rx_ready=0; addr increments mod 2^16 (0xFFFF wraps to 0x0000); remaining count decrements; next state DATA if count>0, else CSUM.
REQ-022 rx_ready SHALL be 1 in every state except WRITE, and 0 during reset.
REQ-023 CSUM: accepted byte equal to running sum -> done pulse; otherwise err pulse; both return to IDLE.
REQ-024 Bytes already written SHALL NOT be rolled back on err.
REQ-025 cpu_hold SHALL rise the cycle after SYNC is accepted and fall the same cycle done or err pulses.
REQ-026 Gap counter SHALL clear on every accepted byte and on entry to ADDR_H; in any non-IDLE state, reaching TIMEOUT cycles without an accepted byte -> err pulse, IDLE.
REQ-027 Running sum and count SHALL clear when SYNC is accepted.
REQ-028 mem_wr SHALL never assert outside WRITE, and SHALL be 0 in any cycle with reset high.
REQ-029 done and err SHALL never assert in the same cycle.

Reset
REQ-030 reset high SHALL force IDLE; rx_ready=0, mem_wr=0, cpu_hold=0, done=0, err=0, mem_addr=0, mem_data=0; sum, count and gap counter cleared.
REQ-031 reset mid-frame SHALL abandon the frame silently, with no err pulse.
REQ-032 First byte acceptance SHALL be possible on the first cycle after reset deasserts.

Structure
REQ-033 Shared package loader_pkg SHALL hold the state enum and the SYNC_BYTE and TIMEOUT defaults.
REQ-034 The gap counter SHALL be sub-module gap_timer (inputs clear, enable; output expired).
REQ-035 Outputs mem_addr/mem_data/mem_wr SHALL connect directly to the memory block's addr/data_in/wr ports.

Verification
REQ-036 Frame 4C 00 10 00 03 AA BB CC 31 -> writes AA@0010, BB@0011, CC@0012; one done pulse; cpu_hold falls the same cycle.
REQ-037 Same frame with CSUM 32 -> three writes occur; one err pulse; no done.
REQ-038 Frame 4C FF FF 00 02 11 22 33 -> 11@FFFF, 22@0000 (wrap); done.
REQ-039 Frame 4C 12 34 00 00 00 -> no mem_wr; done.
REQ-040 TIMEOUT=16, send 4C 00 then idle 16 cycles -> err pulse, back in IDLE; next 4C restarts a frame.
REQ-041 Bytes 00 FF before 4C, and reset asserted after ADDR_L -> leading bytes ignored; after reset, IDLE with no err and cpu_hold=0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the serial memory loader: frame-parser states and
// default values for the sync byte and the inter-byte timeout.
package loader_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'h4C;
   localparam int         TIMEOUT_DEF   = 100000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR_H,
      ST_ADDR_L,
      ST_LEN_H,
      ST_LEN_L,
      ST_DATA,
      ST_WRITE,
      ST_CSUM
   } state_e;

endpackage

// File: rtl/gap_timer.sv
// Counts idle cycles between accepted frame bytes and flags when the allowed
// gap has been used up.
module gap_timer
   import loader_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] gap_q;

   // Expiry lands on the TIMEOUT-th consecutive cycle without an accepted byte.
   assign expired = enable && !clear && (gap_q == LAST);

   always_ff @(posedge clk) begin
      if (clear || !enable) begin
         gap_q <= '0;
      end else if (gap_q != LAST) begin
         gap_q <= gap_q + 1'b1;
      end
   end

endmodule

// File: rtl/mem_loader.sv
// Receives framed bytes (SYNC, address, length, data, checksum) and writes the
// payload into memory while holding the CPU in reset.
module mem_loader
   import loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         TIMEOUT   = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_data,
   output logic        mem_wr,
   output logic        cpu_hold,
   output logic        done,
   output logic        err
);

   state_e      state_q;
   logic [15:0] addr_q;
   logic [15:0] count_q;
   logic [7:0]  data_q;
   logic [7:0]  sum_q;
   logic        done_q;
   logic        err_q;
   logic        accept;
   logic        expired;

   // Strobes are gated by reset so nothing leaks out during the reset cycle itself.
   assign rx_ready = !reset && (state_q != ST_WRITE);
   assign accept   = rx_valid && rx_ready;
   assign mem_wr   = !reset && (state_q == ST_WRITE);
   assign cpu_hold = !reset && (state_q != ST_IDLE);
   assign done     = !reset && done_q;
   assign err      = !reset && err_q;
   assign mem_addr = addr_q;
   assign mem_data = data_q;

   gap_timer #(.TIMEOUT(TIMEOUT)) u_gap_timer (
      .clk     (clk),
      .clear   (reset || accept),
      .enable  (state_q != ST_IDLE),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         count_q <= '0;
         data_q  <= '0;
         sum_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (expired) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (accept && (rx_data == SYNC_BYTE)) begin
                     state_q <= ST_ADDR_H;
                     sum_q   <= '0;
                     count_q <= '0;
                  end
               end
               ST_ADDR_H: begin
                  if (accept) begin
                     addr_q[15:8] <= rx_data;
                     state_q      <= ST_ADDR_L;
                  end
               end
               ST_ADDR_L: begin
                  if (accept) begin
                     addr_q[7:0] <= rx_data;
                     state_q     <= ST_LEN_H;
                  end
               end
               ST_LEN_H: begin
                  if (accept) begin
                     count_q[15:8] <= rx_data;
                     state_q       <= ST_LEN_L;
                  end
               end
               ST_LEN_L: begin
                  if (accept) begin
                     count_q[7:0] <= rx_data;
                     state_q      <= ({count_q[15:8], rx_data} == 16'd0) ? ST_CSUM : ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (accept) begin
                     data_q  <= rx_data;
                     sum_q   <= sum_q + rx_data;
                     state_q <= ST_WRITE;
                  end
               end
               ST_WRITE: begin
                  addr_q  <= addr_q + 16'd1;
                  count_q <= count_q - 16'd1;
                  state_q <= (count_q == 16'd1) ? ST_CSUM : ST_DATA;
               end
               ST_CSUM: begin
                  if (accept) begin
                     if (rx_data == sum_q) begin
                        done_q <= 1'b1;
                     end else begin
                        err_q <= 1'b1;
                     end
                     state_q <= ST_IDLE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed frames plus randomized frames
// compared against a frame-level reference model of the expected writes.
module tb_mem_loader;

   logic        clk;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_wr;
   logic        cpu_hold;
   logic        done;
   logic        err;

   int errors = 0;
   int checks = 0;

   logic [7:0]  frame[$];
   logic [23:0] obsQ[$];
   logic [23:0] expQ[$];
   int  doneCnt = 0;
   int  errCnt = 0;
   int  bothCnt = 0;
   int  resetLeak = 0;
   logic holdAtPulse = 1'b1;
   logic holdBefore = 1'b0;
   logic prevHold = 1'b0;
   bit  randomGaps = 1'b0;

   mem_loader #(.SYNC_BYTE(8'h4C), .TIMEOUT(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_wr   (mem_wr),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Passive monitor: collects writes and pulses, and the hold level around pulses.
   always @(negedge clk) begin
      if (mem_wr) obsQ.push_back({mem_addr, mem_data});
      if (done) doneCnt++;
      if (err) errCnt++;
      if (done && err) bothCnt++;
      if (done || err) begin
         holdAtPulse = cpu_hold;
         holdBefore  = prevHold;
      end
      if (reset && (mem_wr || done || err || rx_ready || cpu_hold)) resetLeak++;
      prevHold = cpu_hold;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic sendByte(input logic [7:0] b);
      int waitCycles = 0;
      if (randomGaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      while (!rx_ready && waitCycles < 10) begin
         @(negedge clk);
         waitCycles++;
      end
      if (waitCycles >= 10) begin
         checks++;
         errors++;
         $error("[TB] FAIL sendByte observed=rx_ready_low expected=rx_ready_high");
      end
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic clearMonitor();
      obsQ.delete();
      doneCnt = 0;
      errCnt = 0;
      bothCnt = 0;
      holdAtPulse = 1'b1;
      holdBefore = 1'b0;
   endtask

   // Sends the frame in 'frame' and checks it against the frame-level model.
   task automatic applyStimulus(input string tag);
      int a, n, s;
      bit expDone;
      a = {frame[1], frame[2]};
      n = {frame[3], frame[4]};
      s = 0;
      expQ.delete();
      for (int i = 0; i < n; i++) begin
         logic [15:0] wa;
         wa = 16'((a + i) % 65536);
         expQ.push_back({wa, frame[5 + i]});
         s = (s + int'(frame[5 + i])) % 256;
      end
      expDone = (s == int'(frame[5 + n]));
      clearMonitor();
      foreach (frame[i]) sendByte(frame[i]);
      repeat (3) @(negedge clk);
      checkOutput({tag, ".nwrites"}, obsQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
         checkOutput($sformatf("%s.write%0d", tag, i), obsQ[i], expQ[i]);
      checkOutput({tag, ".done"}, doneCnt, expDone ? 1 : 0);
      checkOutput({tag, ".err"}, errCnt, expDone ? 0 : 1);
      checkOutput({tag, ".both"}, bothCnt, 0);
      checkOutput({tag, ".holdAtPulse"}, holdAtPulse, 0);
      checkOutput({tag, ".holdBefore"}, holdBefore, 1);
      checkOutput({tag, ".idleReady"}, {cpu_hold, rx_ready}, 2'b01);
   endtask

   task automatic applyReset(input int cycles);
      reset = 1'b1;
      rx_valid = 1'b0;
      repeat (cycles) @(negedge clk);
      checkOutput("reset.outputs", {rx_ready, mem_wr, cpu_hold, done, err}, 5'b0);
      reset = 1'b0;
   endtask

   initial begin
      logic [15:0] ra;
      int rn;
      logic [7:0] rs;
      reset = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("reset.outputs", {rx_ready, mem_wr, cpu_hold, done, err}, 5'b0);
      checkOutput("reset.addrData", {mem_addr, mem_data}, 24'h0);
      reset = 1'b0;

      $display("[TB] directed frames");
      frame = '{8'h4C, 8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
      applyStimulus("goodFrame");
      frame = '{8'h4C, 8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h32};
      applyStimulus("badCsum");
      frame = '{8'h4C, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
      applyStimulus("addrWrap");
      frame = '{8'h4C, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00};
      applyStimulus("zeroLen");

      $display("[TB] timeout");
      clearMonitor();
      sendByte(8'h4C);
      sendByte(8'h00);
      repeat (15) @(negedge clk);
      checkOutput("timeout.beforeLimit", {err, cpu_hold}, 2'b01);
      @(negedge clk);
      checkOutput("timeout.errPulse", {err, cpu_hold, done}, 3'b100);
      @(negedge clk);
      checkOutput("timeout.errCount", errCnt, 1);
      frame = '{8'h4C, 8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
      applyStimulus("afterTimeout");

      $display("[TB] leading junk and mid-frame reset");
      clearMonitor();
      sendByte(8'h00);
      sendByte(8'hFF);
      checkOutput("junk.noHold", cpu_hold, 0);
      sendByte(8'h4C);
      checkOutput("junk.holdAfterSync", cpu_hold, 1);
      sendByte(8'h12);
      sendByte(8'h34);
      applyReset(2);
      @(negedge clk);
      checkOutput("midReset.idle", {cpu_hold, rx_ready, err}, 3'b010);
      checkOutput("midReset.noPulses", errCnt + doneCnt, 0);
      checkOutput("midReset.addrData", {mem_addr, mem_data}, 24'h0);

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rx_data = 8'h4C;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      checkOutput("firstCycleAccept", cpu_hold, 1);
      applyReset(1);

      $display("[TB] random frames");
      randomGaps = 1'b1;
      for (int f = 0; f < 8; f++) begin
         ra = (f % 3 == 0) ? 16'(16'hFFFF - $urandom_range(0, 3)) : 16'($urandom);
         rn = $urandom_range(0, 6);
         rs = 8'h00;
         frame = '{8'h4C, ra[15:8], ra[7:0], 8'h00, 8'(rn)};
         for (int i = 0; i < rn; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            frame.push_back(d);
            rs = rs + d;
         end
         frame.push_back(($urandom_range(0, 3) == 0) ? rs ^ 8'h5A : rs);
         applyStimulus($sformatf("rand%0d", f));
      end

      checkOutput("resetLeak", resetLeak, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
